// File: rtl/sar_clk_gen.sv
// Programmable comparator-clock generator for the time-domain SAR loop.
// Produces a bounded burst of clk_cmp periods plus a phase-delayed copy, then a done pulse.
module sar_clk_gen #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [DIV_W-1:0] div,
    input  logic [DIV_W-1:0] shift,
    input  logic [CNT_W-1:0] cycles,
    output logic             clk_cmp,
    output logic             clk_cmp_shifted,
    output logic [CNT_W-1:0] cyc_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [DIV_W-1:0] h_reg;
    logic [DIV_W:0]   s_reg;
    logic [CNT_W-1:0] last_reg;
    logic [DIV_W:0]   ph;
    logic             started;

    logic [DIV_W-1:0] h_in;
    logic [DIV_W:0]   s_in;
    logic [DIV_W:0]   in_period_m1;
    logic [DIV_W:0]   period;
    logic [DIV_W:0]   period_m1;
    logic             wrap;
    logic [DIV_W:0]   ph_next;
    logic [DIV_W:0]   sp_next;
    logic             started_next;
    logic             cmp_next;
    logic             sh_next;

    // The shifted phase wraps by adding (2H - S) instead of subtracting, so it never underflows.
    always_comb begin
        h_in         = (div == '0) ? DIV_W'(1) : div;
        in_period_m1 = {h_in, 1'b0} - (DIV_W+1)'(1);
        s_in         = ({1'b0, shift} > in_period_m1) ? in_period_m1 : {1'b0, shift};
        period       = {h_reg, 1'b0};
        period_m1    = period - (DIV_W+1)'(1);
        wrap         = (ph == period_m1);
        ph_next      = wrap ? '0 : ph + (DIV_W+1)'(1);
        sp_next      = (ph_next >= s_reg) ? (ph_next - s_reg) : (ph_next + (period - s_reg));
        started_next = started | (ph_next == s_reg);
        cmp_next     = (ph_next < {1'b0, h_reg});
        sh_next      = started_next & (sp_next < {1'b0, h_reg});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            h_reg           <= '0;
            s_reg           <= '0;
            last_reg        <= '0;
            ph              <= '0;
            started         <= 1'b0;
            clk_cmp         <= 1'b0;
            clk_cmp_shifted <= 1'b0;
            cyc_idx         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else if (!en) begin
            state           <= IDLE;
            ph              <= '0;
            started         <= 1'b0;
            clk_cmp         <= 1'b0;
            clk_cmp_shifted <= 1'b0;
            cyc_idx         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clk_cmp         <= 1'b0;
                    clk_cmp_shifted <= 1'b0;
                    cyc_idx         <= '0;
                    busy            <= 1'b0;
                    done            <= 1'b0;
                    if (start) begin
                        h_reg           <= h_in;
                        s_reg           <= s_in;
                        last_reg        <= cycles;
                        ph              <= '0;
                        started         <= (s_in == '0);
                        clk_cmp         <= 1'b1;
                        clk_cmp_shifted <= (s_in == '0);
                        busy            <= 1'b1;
                        state           <= RUN;
                    end
                end
                RUN: begin
                    // End of the final period wins over the cyc_idx increment.
                    if (wrap && (cyc_idx == last_reg)) begin
                        clk_cmp <= 1'b0;
                        ph      <= '0;
                        if (s_reg != '0) begin
                            started         <= started_next;
                            clk_cmp_shifted <= sh_next;
                            state           <= DRAIN;
                        end else begin
                            clk_cmp_shifted <= 1'b0;
                            busy            <= 1'b0;
                            done            <= 1'b1;
                            state           <= DONE;
                        end
                    end else begin
                        ph              <= ph_next;
                        started         <= started_next;
                        clk_cmp         <= cmp_next;
                        clk_cmp_shifted <= sh_next;
                        if (wrap) begin
                            cyc_idx <= cyc_idx + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    clk_cmp <= 1'b0;
                    if (ph == s_reg - (DIV_W+1)'(1)) begin
                        clk_cmp_shifted <= 1'b0;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                        state           <= DONE;
                    end else begin
                        ph              <= ph_next;
                        clk_cmp_shifted <= sh_next;
                    end
                end
                DONE: begin
                    clk_cmp         <= 1'b0;
                    clk_cmp_shifted <= 1'b0;
                    cyc_idx         <= '0;
                    busy            <= 1'b0;
                    done            <= 1'b0;
                    state           <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_clk_gen.sv
// Scoreboard bench for sar_clk_gen: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_sar_clk_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic       start;
    logic [7:0] div;
    logic [7:0] shift;
    logic [3:0] cycles;
    logic       clk_cmp;
    logic       clk_cmp_shifted;
    logic [3:0] cyc_idx;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       cmp;
        logic       sh;
        logic       busy;
        logic       done;
        logic [3:0] cyc;
        logic       chk_cyc;
    } exp_t;

    exp_t sb_q[$];

    sar_clk_gen #(.DIV_W(8), .CNT_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .start           (start),
        .div             (div),
        .shift           (shift),
        .cycles          (cycles),
        .clk_cmp         (clk_cmp),
        .clk_cmp_shifted (clk_cmp_shifted),
        .cyc_idx         (cyc_idx),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected waveform of one burst written directly from cycle numbers (cycle 1 follows the start edge).
    function automatic void push_burst(input int h, input int s, input int n, input int abort_at);
        exp_t e;
        int   r;
        int   last;
        r    = n * 2 * h;
        last = (abort_at > 0) ? abort_at : r + s;
        for (int k = 1; k <= last; k++) begin
            int p;
            int j;
            p         = 2 * h;
            j         = k - 1 - s;
            e.cmp     = (k <= r) && (((k - 1) % p) < h);
            e.sh      = (j >= 0) && ((j % p) < h);
            e.busy    = 1'b1;
            e.done    = 1'b0;
            e.cyc     = (k <= r) ? 4'((k - 1) / p) : 4'(n - 1);
            e.chk_cyc = 1'b1;
            sb_q.push_back(e);
        end
        if (abort_at == 0) begin
            e = '{cmp: 1'b0, sh: 1'b0, busy: 1'b0, done: 1'b1, cyc: 4'd0, chk_cyc: 1'b0};
            sb_q.push_back(e);
        end
        push_idle(2);
    endfunction

    function automatic void push_idle(input int count);
        exp_t e;
        e = '{cmp: 1'b0, sh: 1'b0, busy: 1'b0, done: 1'b0, cyc: 4'd0, chk_cyc: 1'b1};
        for (int i = 0; i < count; i++) sb_q.push_back(e);
    endfunction

    // Monitor: compares the DUT against the oldest queued expectation once per cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (clk_cmp !== e.cmp || clk_cmp_shifted !== e.sh || busy !== e.busy ||
                done !== e.done || (e.chk_cyc && cyc_idx !== e.cyc)) begin
                errors++;
                $display("[TB] FAIL cycle_vec t=%0t got cmp=%b sh=%b busy=%b done=%b idx=%0d expected cmp=%b sh=%b busy=%b done=%b idx=%0d",
                         $time, clk_cmp, clk_cmp_shifted, busy, done, cyc_idx,
                         e.cmp, e.sh, e.busy, e.done, e.cyc);
            end
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while (sb_q.size() > 0 && c < 1000) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout got %0d pending expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    // abort_kind: 0 none, 1 drop en, 2 pulse rst (both during abort_cyc).
    task automatic apply_stimulus(input logic [7:0] d, input logic [7:0] sh, input logic [3:0] cy,
                                  input int h, input int s, input int abort_kind, input int abort_cyc,
                                  input int repulse_cyc, input int redrive_cyc, input logic [7:0] redrive_div);
        int c;
        @(posedge clk);
        #1;
        div    = d;
        shift  = sh;
        cycles = cy;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_burst(h, s, int'(cy) + 1, (abort_kind != 0) ? abort_cyc : 0);
        c = 1;
        while (sb_q.size() > 0 && c < 1000) begin
            start = (c == repulse_cyc);
            if (c == redrive_cyc) div = redrive_div;
            if (abort_kind == 1 && c == abort_cyc) en = 1'b0;
            if (abort_kind == 2 && c == abort_cyc) rst = 1'b1;
            @(posedge clk);
            #1;
            en    = 1'b1;
            rst   = 1'b0;
            start = 1'b0;
            c++;
        end
        wait_drain("burst");
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b1;
        start  = 1'b0;
        div    = 8'd0;
        shift  = 8'd0;
        cycles = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        push_idle(2);
        wait_drain("reset");

        // H=4 S=0 N=3, start re-pulsed in the DONE cycle (25)
        apply_stimulus(8'd4, 8'd0, 4'd2, 4, 0, 0, 0, 25, 0, 8'd0);
        // H=4 S=2 single period with drain
        apply_stimulus(8'd4, 8'd2, 4'd0, 4, 2, 0, 0, 0, 0, 8'd0);
        // div=0 treated as H=1
        apply_stimulus(8'd0, 8'd0, 4'd3, 1, 0, 0, 0, 0, 0, 8'd0);
        // shift 9 saturates to 2H-1 = 3
        apply_stimulus(8'd2, 8'd9, 4'd0, 2, 3, 0, 0, 0, 0, 8'd0);
        // en dropped in cycle 10
        apply_stimulus(8'd4, 8'd0, 4'd5, 4, 0, 1, 10, 0, 0, 8'd0);
        // rst pulsed in cycle 10, config registers cleared
        apply_stimulus(8'd4, 8'd3, 4'd5, 4, 3, 2, 10, 0, 0, 8'd0);
        check_output("h_reg_cleared", int'(dut.h_reg), 0);
        check_output("s_reg_cleared", int'(dut.s_reg), 0);
        check_output("last_reg_cleared", int'(dut.last_reg), 0);
        // start re-pulsed mid-burst
        apply_stimulus(8'd4, 8'd1, 4'd2, 4, 1, 0, 0, 5, 0, 8'd0);
        // div changed to 7 mid-burst, then a burst using 7
        apply_stimulus(8'd4, 8'd0, 4'd1, 4, 0, 0, 0, 0, 3, 8'd7);
        apply_stimulus(8'd7, 8'd0, 4'd0, 7, 0, 0, 0, 0, 0, 8'd0);
        // maximum burst length: 16 periods
        apply_stimulus(8'd0, 8'd0, 4'd15, 1, 0, 0, 0, 0, 0, 8'd0);

        // start with en low is ignored
        @(posedge clk);
        #1;
        en    = 1'b0;
        start = 1'b1;
        div   = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        en    = 1'b1;
        push_idle(3);
        wait_drain("start_en_low");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
